// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DW_DEF = 32;
    localparam int SEL_W  = DW_DEF / 8;

    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_TIMEOUT = 1'b1;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator: command stream in, bus cycle,
// response stream out, with a bounded wait on the slave acknowledge.
//
// state | meaning
// IDLE  | ready for a command, bus idle
// BUS   | CYC/STB asserted, waiting for ACK or timeout
// RESP  | response held until consumed
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_adr,
    input  logic [DW-1:0]     cmd_dat,
    input  logic [DW/8-1:0]   cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_dat,
    output logic              rsp_err,
    output logic              busy,
    output logic              wb_CYC,
    output logic              wb_STB,
    output logic              wb_WE,
    output logic [DW/8-1:0]   wb_SEL,
    output logic [AW-1:0]     wb_ADR,
    output logic [DW-1:0]     wb_DAT_MOSI,
    input  logic              wb_ACK,
    input  logic [DW-1:0]     wb_DAT_MISO
);

    localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [DW/8-1:0]   sel_q, sel_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     mosi_q, mosi_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_hit;

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            mosi_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = BUS;
            BUS:     if (wb_ACK || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs; ACK is checked before the timeout so it wins a tie.
    always_comb begin
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        mosi_d      = mosi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cyc_d  = 1'b1;
                    stb_d  = 1'b1;
                    we_d   = cmd_we;
                    sel_d  = cmd_sel;
                    adr_d  = cmd_adr;
                    mosi_d = cmd_dat;
                    cnt_d  = '0;
                end
            end
            BUS: begin
                if (wb_ACK) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wb_DAT_MISO;
                    rsp_err_d   = RSP_OK;
                    rsp_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = RSP_TIMEOUT;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign wb_CYC      = cyc_q;
    assign wb_STB      = stb_q;
    assign wb_WE       = we_q;
    assign wb_SEL      = sel_q;
    assign wb_ADR      = adr_q;
    assign wb_DAT_MOSI = mosi_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_dat     = rsp_dat_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a 4-cycle timeout; inputs change and
// outputs are sampled on the falling clock edge.
module tb_wb_cmd_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        wb_CYC;
    logic        wb_STB;
    logic        wb_WE;
    logic [3:0]  wb_SEL;
    logic [31:0] wb_ADR;
    logic [31:0] wb_DAT_MOSI;
    logic        wb_ACK;
    logic [31:0] wb_DAT_MISO;

    int n_checks = 0;
    int n_fail   = 0;

    wb_cmd_master #(
        .AW(32), .DW(32), .TIMEOUT_CYC(4), .CNT_W(8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .wb_CYC      (wb_CYC),
        .wb_STB      (wb_STB),
        .wb_WE       (wb_WE),
        .wb_SEL      (wb_SEL),
        .wb_ADR      (wb_ADR),
        .wb_DAT_MOSI (wb_DAT_MOSI),
        .wb_ACK      (wb_ACK),
        .wb_DAT_MISO (wb_DAT_MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (wb_CYC !== 1'b0)  begin n_fail++; $display("FAIL reset_cyc: got %b want 0", wb_CYC); end
        n_checks++; if (wb_STB !== 1'b0)  begin n_fail++; $display("FAIL reset_stb: got %b want 0", wb_STB); end
        n_checks++; if (wb_WE !== 1'b0)   begin n_fail++; $display("FAIL reset_we: got %b want 0", wb_WE); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (wb_ADR !== 32'h0 || wb_DAT_MOSI !== 32'h0 || wb_SEL !== 4'h0 || rsp_dat !== 32'h0)
            begin n_fail++; $display("FAIL reset_data: adr %h mosi %h sel %h rsp_dat %h want all 0", wb_ADR, wb_DAT_MOSI, wb_SEL, rsp_dat); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_zero_wait_write();
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        n_checks++; if (wb_CYC !== 1'b1 || wb_STB !== 1'b1 || wb_WE !== 1'b1)
            begin n_fail++; $display("FAIL wr_ctrl: cyc %b stb %b we %b want 111", wb_CYC, wb_STB, wb_WE); end
        n_checks++; if (wb_ADR !== 32'h3000_0004) begin n_fail++; $display("FAIL wr_adr: got %h want 30000004", wb_ADR); end
        n_checks++; if (wb_DAT_MOSI !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_mosi: got %h want deadbeef", wb_DAT_MOSI); end
        n_checks++; if (wb_SEL !== 4'hF) begin n_fail++; $display("FAIL wr_sel: got %h want f", wb_SEL); end
        n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1)
            begin n_fail++; $display("FAIL wr_busy: cmd_ready %b busy %b want 0 1", cmd_ready, busy); end
        cmd_valid   = 1'b0;
        cmd_adr     = 32'h5555_5555;
        cmd_dat     = 32'h1111_1111;
        wb_ACK      = 1'b1;
        wb_DAT_MISO = 32'h7777_7777;
        @(negedge clk);
        wb_ACK = 1'b0;
        n_checks++; if (wb_CYC !== 1'b0 || wb_STB !== 1'b0 || wb_WE !== 1'b0)
            begin n_fail++; $display("FAIL wr_end_ctrl: cyc %b stb %b we %b want 000", wb_CYC, wb_STB, wb_WE); end
        n_checks++; if (wb_ADR !== 32'h3000_0004 || wb_DAT_MOSI !== 32'hDEAD_BEEF)
            begin n_fail++; $display("FAIL wr_hold: adr %h mosi %h want 30000004 deadbeef", wb_ADR, wb_DAT_MOSI); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0)
            begin n_fail++; $display("FAIL wr_rsp: valid %b err %b dat %h want 1 0 0", rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            begin n_fail++; $display("FAIL wr_done: rsp_valid %b cmd_ready %b want 0 1", rsp_valid, cmd_ready); end
    endtask

    // Slave acks in the 4th STB cycle, which is also the timeout edge.
    task automatic read_ack4(input string name, input logic [31:0] adr, input logic [31:0] rdata);
        issue(1'b0, adr, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n_checks++; if (wb_CYC !== 1'b1 || wb_WE !== 1'b0)
                begin n_fail++; $display("FAIL %s_cyc%0d: cyc %b we %b want 1 0", name, i, wb_CYC, wb_WE); end
            if (i == 3) begin
                wb_ACK      = 1'b1;
                wb_DAT_MISO = rdata;
            end
        end
        @(negedge clk);
        wb_ACK = 1'b0;
        n_checks++; if (wb_CYC !== 1'b0) begin n_fail++; $display("FAIL %s_cyc_end: got %b want 0", name, wb_CYC); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== rdata)
            begin n_fail++; $display("FAIL %s_rsp: valid %b err %b dat %h want 1 0 %h", name, rsp_valid, rsp_err, rsp_dat, rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_wait3();
        read_ack4("rd3", 32'h0000_0100, 32'h1234_5678);
    endtask

    task automatic test_ack_on_timeout_edge();
        read_ack4("ack_to", 32'h0000_0200, 32'hA5A5_A5A5);
    endtask

    task automatic test_timeout();
        issue(1'b0, 32'h0000_0300, 32'h0, 4'h3);
        wb_DAT_MISO = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n_checks++; if (wb_CYC !== 1'b1) begin n_fail++; $display("FAIL to_cyc%0d: got %b want 1", i, wb_CYC); end
        end
        @(negedge clk);
        n_checks++; if (wb_CYC !== 1'b0 || wb_STB !== 1'b0)
            begin n_fail++; $display("FAIL to_cyc_end: cyc %b stb %b want 0 0", wb_CYC, wb_STB); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0)
            begin n_fail++; $display("FAIL to_rsp: valid %b err %b dat %h want 1 1 0", rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wb_ACK    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || wb_CYC !== 1'b0)
                begin n_fail++; $display("FAIL idle_ack%0d: rsp_valid %b busy %b cyc %b want 0 0 0", i, rsp_valid, busy, wb_CYC); end
        end
        wb_ACK = 1'b0;
    endtask

    task automatic test_back_to_back_backpressure();
        issue(1'b0, 32'h0000_0400, 32'h0, 4'h1);
        @(negedge clk);
        issue(1'b1, 32'h0000_0500, 32'h0BAD_F00D, 4'hC);
        wb_ACK      = 1'b1;
        wb_DAT_MISO = 32'hCAFE_F00D;
        @(negedge clk);
        wb_ACK      = 1'b0;
        wb_DAT_MISO = 32'h0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'hCAFE_F00D || rsp_err !== 1'b0)
                begin n_fail++; $display("FAIL bp_rsp%0d: valid %b dat %h err %b want 1 cafef00d 0", i, rsp_valid, rsp_dat, rsp_err); end
            n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1 || wb_CYC !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold%0d: cmd_ready %b busy %b cyc %b want 0 1 0", i, cmd_ready, busy, wb_CYC); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_CYC !== 1'b0)
            begin n_fail++; $display("FAIL bp_handshake: rsp_valid %b cmd_ready %b cyc %b want 0 1 0", rsp_valid, cmd_ready, wb_CYC); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (wb_CYC !== 1'b1 || wb_WE !== 1'b1 || wb_ADR !== 32'h0000_0500 || wb_SEL !== 4'hC)
            begin n_fail++; $display("FAIL bp_second: cyc %b we %b adr %h sel %h want 1 1 00000500 c", wb_CYC, wb_WE, wb_ADR, wb_SEL); end
        wb_ACK = 1'b1;
        @(negedge clk);
        wb_ACK = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0)
            begin n_fail++; $display("FAIL bp_second_rsp: valid %b dat %h want 1 0", rsp_valid, rsp_dat); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        issue(1'b0, 32'h0000_0600, 32'h0, 4'hF);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (wb_CYC !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: cyc %b want 1", wb_CYC); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (wb_CYC !== 1'b0 || wb_STB !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid_async: cyc %b stb %b rsp_valid %b busy %b want 0000", wb_CYC, wb_STB, rsp_valid, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid_release: cmd_ready %b rsp_valid %b want 1 0", cmd_ready, rsp_valid); end
        issue(1'b0, 32'h0000_0700, 32'h0, 4'hF);
        @(negedge clk);
        cmd_valid   = 1'b0;
        wb_ACK      = 1'b1;
        wb_DAT_MISO = 32'h0BAD_C0DE;
        n_checks++; if (wb_CYC !== 1'b1 || wb_ADR !== 32'h0000_0700)
            begin n_fail++; $display("FAIL rst_fresh_cyc: cyc %b adr %h want 1 00000700", wb_CYC, wb_ADR); end
        @(negedge clk);
        wb_ACK = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0BAD_C0DE)
            begin n_fail++; $display("FAIL rst_fresh_rsp: valid %b err %b dat %h want 1 0 0badc0de", rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_adr     = '0;
        cmd_dat     = '0;
        cmd_sel     = '0;
        rsp_ready   = 1'b0;
        wb_ACK      = 1'b0;
        wb_DAT_MISO = '0;
        test_reset();
        test_zero_wait_write();
        test_read_wait3();
        test_timeout();
        test_ack_on_timeout_edge();
        test_back_to_back_backpressure();
        test_reset_mid_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic single-transfer initiator; drives the wb_CYC/wb_STB/wb_WE/wb_SEL/wb_ADR/wb_DAT_MOSI slave interface of the DSP48 block.
- Converts a valid/ready command stream into bus cycles and returns read data or error over a valid/ready response stream.
- Serves as the on-chip bring-up/test initiator: the LA or IO-pad sequencer feeds it, and the bench uses it as the reference master.
- One outstanding transfer; bounded wait enforced by a timeout counter.

Parameters:
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- TIMEOUT_CYC, 255, max cycles with STB high and no ACK before abort; 0 disables timeout.
- CNT_W, 8, timeout counter width; must hold TIMEOUT_CYC.

Ports:
- wb_clk_i  in  1  sole clock; all logic rising-edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  AW  byte address.
- cmd_dat  in  DW  write data.
- cmd_sel  in  DW/8  byte lanes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_dat  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout abort.
- busy  out  1  high in any state except IDLE.
- wb_CYC  out  1  bus cycle.
- wb_STB  out  1  strobe.
- wb_WE  out  1  write enable.
- wb_SEL  out  DW/8  byte select.
- wb_ADR  out  AW  address.
- wb_DAT_MOSI  out  DW  write data.
- wb_ACK  in  1  slave acknowledge.
- wb_DAT_MISO  in  DW  slave read data.

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE.
  - wb_CYC, wb_STB, wb_WE, rsp_valid, rsp_err, busy = 0.
  - wb_SEL, wb_ADR, wb_DAT_MOSI, rsp_dat = 0; timeout counter = 0.
  - cmd_ready=1 after release.
- All outputs are registered, except cmd_ready and busy, which decode state only.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid at edge N: latch we/adr/dat/sel onto wb_* regs, set CYC=STB=1, clear counter, go BUS. wb_CYC is high in cycle N+1.
  - BUS: cmd_ready=0; wb_* outputs held stable.
    - wb_ACK=1 at an edge: CYC=STB=WE=0 that edge. rsp_dat = wb_DAT_MISO if read, else 0. rsp_err=0, rsp_valid=1, go RESP.
    - Else counter+1. If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: CYC=STB=WE=0, rsp_err=1, rsp_dat=0, rsp_valid=1, go RESP.
    - ACK and timeout on the same edge: ACK wins, rsp_err=0.
  - RESP: hold rsp_* stable until rsp_ready. On rsp_valid&rsp_ready: rsp_valid=0, go IDLE; the next command is accepted no earlier than the following edge.
- Minimum latency: zero-wait slave gives accept at N, ACK sampled at N+1, rsp_valid high from N+2. Back-to-back issue rate is one transfer per 3 cycles.
- wb_ACK outside BUS is ignored: no state change, no response.
- cmd_* inputs may change freely outside the accept edge; only the values at the accept edge are used.
- wb_ADR/wb_DAT_MOSI/wb_SEL keep their last values after a cycle ends (no bus glitch); wb_WE returns to 0.
- Reset asserted mid-BUS: CYC/STB drop immediately (async); no response is produced.

Decomposition:
- Package wb_cmd_pkg:
  - state enum {IDLE, BUS, RESP}, 2-bit encoding.
  - localparam SEL_W = DW/8.
  - RSP_OK/RSP_TIMEOUT constants.
- No sub-module; the timeout counter stays inline.

Test Plan:
- Zero-wait write: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave ACKs the first STB cycle -> CYC high exactly 1 cycle with those values, rsp_valid one cycle later, rsp_err=0, rsp_dat=0.
- Read with 3 wait states: slave returns 0x1234_5678 on ACK -> CYC high 4 cycles, rsp_dat=0x1234_5678, rsp_err=0.
- Timeout: TIMEOUT_CYC=4, slave never ACKs -> CYC high exactly 4 cycles, then rsp_err=1, rsp_dat=0; a later ACK in IDLE produces no response.
- ACK on the timeout edge: TIMEOUT_CYC=4, ACK in 4th STB cycle with data 0xA5A5_A5A5 -> rsp_err=0, rsp_dat=0xA5A5_A5A5.
- Response backpressure: rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0, busy=1; a second cmd_valid is not accepted until the edge after the response handshake.
- Async reset mid-BUS: wb_rst_ni low during wait states -> CYC/STB/rsp_valid 0 before the next edge; after release cmd_ready=1 and a fresh read completes normally.
